// File: rtl/mem_stage_dcache_ctrl.sv
// MEM-stage data-cache sequencer: word/byte loads and stores plus two-access LDI/STI (pointer fetch, then data).
// Latency: request cycle + one cycle per cache access until dcache_resp, then DONE (2 cycles plain, 3 indirect on 1-cycle hits).
// Backpressure: stall freezes upstream while an access is outstanding; DONE is held while hold=1 so nothing reissues.
// Optional: define DCACHE_PERF_CNT_EN to add saturating perf_accesses / perf_stall_cycles counters.
module mem_stage_dcache_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid,
    input  logic              dcacheR,
    input  logic              dcacheW,
    input  logic              indirect,
    input  logic              byte_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              hold,
    output logic              stall,
    output logic [DATA_W-1:0] rdata_out,
    output logic              dcache_read,
    output logic              dcache_write,
    output logic [ADDR_W-1:0] dcache_address,
    output logic [DATA_W-1:0] dcache_wdata,
    output logic [1:0]        dcache_byte_enable,
    input  logic [DATA_W-1:0] dcache_rdata,
    input  logic              dcache_resp
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [15:0]       perf_accesses,
    output logic [15:0]       perf_stall_cycles
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] PTR    = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_byte;
    logic              lat_write;
    logic              lat_ind;
    logic [ADDR_W-1:0] ptr_reg;

    logic              req;
    logic              resp_accept;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] load_fmt;

    assign req         = valid & (dcacheR | dcacheW);
    assign resp_accept = dcache_resp & ((state == PTR) | (state == ACCESS));
    assign ea          = lat_ind ? ptr_reg : lat_addr;

    // Load formatting: byte loads pick the lane addressed by ea[0] and sign-extend it.
    always_comb begin
        load_fmt = dcache_rdata;
        if (lat_byte) begin
            if (ea[0])
                load_fmt = {{(DATA_W-8){dcache_rdata[15]}}, dcache_rdata[15:8]};
            else
                load_fmt = {{(DATA_W-8){dcache_rdata[7]}}, dcache_rdata[7:0]};
        end
    end

    // Cache strobes and stall are decoded from state and the latched request, so they hold steady until resp.
    always_comb begin
        stall              = 1'b0;
        dcache_read        = 1'b0;
        dcache_write       = 1'b0;
        dcache_address     = '0;
        dcache_wdata       = '0;
        dcache_byte_enable = 2'b00;
        case (state)
            IDLE: begin
                // Gated by reset so a live request cannot show stall while the block is held in reset.
                stall = req & reset_n;
            end
            PTR: begin
                stall              = 1'b1;
                dcache_read        = 1'b1;
                dcache_address     = {lat_addr[ADDR_W-1:1], 1'b0};
                dcache_byte_enable = 2'b11;
            end
            ACCESS: begin
                stall          = 1'b1;
                dcache_read    = ~lat_write;
                dcache_write   = lat_write;
                dcache_address = {ea[ADDR_W-1:1], 1'b0};
                if (lat_byte) begin
                    dcache_byte_enable = ea[0] ? 2'b10 : 2'b01;
                    dcache_wdata       = {lat_wdata[7:0], lat_wdata[7:0]};
                end else begin
                    dcache_byte_enable = 2'b11;
                    dcache_wdata       = lat_wdata;
                end
            end
            default: begin
                // DONE: access complete, pipeline free to advance once hold drops.
            end
        endcase
    end

    // Sequencer: latch the request, walk pointer/data accesses on each resp, park in DONE while held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_byte  <= 1'b0;
            lat_write <= 1'b0;
            lat_ind   <= 1'b0;
            ptr_reg   <= '0;
            rdata_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        lat_byte  <= byte_op;
                        lat_write <= dcacheW;   // R and W together resolve to a write
                        lat_ind   <= indirect;
                        state     <= indirect ? PTR : ACCESS;
                    end
                end
                PTR: begin
                    if (dcache_resp) begin
                        ptr_reg <= dcache_rdata;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (dcache_resp) begin
                        if (!lat_write)
                            rdata_out <= load_fmt;
                        state <= DONE;
                    end
                end
                default: begin
                    if (!hold)
                        state <= IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    // Saturating counters of accepted cache responses and stalled cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_accesses     <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (resp_accept && (perf_accesses != 16'hFFFF))
                perf_accesses <= perf_accesses + 16'd1;
            if (stall && (perf_stall_cycles != 16'hFFFF))
                perf_stall_cycles <= perf_stall_cycles + 16'd1;
        end
    end
`else
    logic unused_resp_accept;
    assign unused_resp_accept = resp_accept;
`endif

endmodule

// File: doc/mem_stage_dcache_ctrl.md
Name: mem_stage_dcache_ctrl

Overview:
- MEM-stage sequencer that consumes the memory fields of the decoded control word (`dcacheR`/`dcacheW`, plus indirect and byte qualifiers) and runs the data-cache request/response handshake.
- Issues word/byte reads and writes, and the two-access LDI/STI sequence (pointer fetch, then data access).
- Stalls the pipeline while any access is outstanding.
- Returns formatted load data to the MEM/WB latch.

Parameters:
- ADDR_W, 16, address width (word-addressed LC-3b bytes; bit 0 = byte select)
- DATA_W, 16, data width; must be 16

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- valid  in  1  MEM-stage latch holds a live instruction
- dcacheR  in  1  control-word read request
- dcacheW  in  1  control-word write request
- indirect  in  1  LDI/STI: first read a pointer at addr, then access the pointer's address
- byte_op  in  1  LDB/STB: byte access
- addr  in  ADDR_W  effective address from EX
- wdata  in  DATA_W  store data (byte stores use bits 7:0)
- hold  in  1  external stall (e.g. fetch miss); MEM stage must not advance
- stall  out  1  MEM access in progress; freeze all upstream stages
- rdata_out  out  DATA_W  formatted load result
- dcache_read  out  1  cache read strobe
- dcache_write  out  1  cache write strobe
- dcache_address  out  ADDR_W  cache address
- dcache_wdata  out  DATA_W  cache write data
- dcache_byte_enable  out  2  lane enables
- dcache_rdata  in  DATA_W  cache read data
- dcache_resp  in  1  cache completion, one-cycle pulse

Behaviour:
- Reset (async, reset_n=0): state=IDLE. stall, all dcache_* strobes, dcache_address, dcache_wdata, dcache_byte_enable, rdata_out, and the pointer register all go to 0. An access in flight is abandoned, and a later dcache_resp in IDLE is ignored.
- States: IDLE, PTR, ACCESS, DONE.
- IDLE:
  - req = valid & (dcacheR | dcacheW).
  - stall = req, combinationally.
  - On req, go to PTR if indirect, else ACCESS. Latch addr, wdata, byte_op, dcacheW, indirect.
- PTR:
  - dcache_read=1, dcache_address={latched addr[15:1],0}, byte_enable=2'b11.
  - Hold strobe and address stable until dcache_resp.
  - On resp, ptr_reg <= dcache_rdata, go to ACCESS.
- ACCESS:
  - ea = indirect ? ptr_reg : latched addr.
  - Read if !dcacheW, else write. Strobes stay stable until dcache_resp; then go to DONE.
  - Word access: address={ea[15:1],0}, byte_enable=2'b11, dcache_wdata=wdata.
  - Byte access: address={ea[15:1],0}, byte_enable = ea[0] ? 2'b10 : 2'b01, dcache_wdata={wdata[7:0],wdata[7:0]}.
  - Load result, registered into rdata_out on the resp edge:
    - word: dcache_rdata
    - byte: sign-extended dcache_rdata[15:8] if ea[0], else sign-extended [7:0]
- DONE:
  - stall=0, no strobes.
  - If hold=1, remain in DONE so the same instruction is not reissued.
  - If hold=0, go to IDLE; the pipeline advances on this edge.
- Stores leave rdata_out unchanged. rdata_out holds its value until the next completed load.
- dcacheR and dcacheW both set: treat as write.
- Minimum latency, 1-cycle cache hit:
  - plain access: stall high for 2 cycles (IDLE, ACCESS); DONE follows.
  - indirect: stall high for 3 cycles.
- dcache_resp outside PTR/ACCESS: ignored.
- valid deasserting mid-access: ignored; the latched request completes.

Optional Feature:
- Macro: DCACHE_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_accesses[15:0] and perf_stall_cycles[15:0], reset to 0.
  - perf_accesses increments on each dcache_resp accepted in PTR or ACCESS.
  - perf_stall_cycles increments every cycle stall=1.
  - Both counters saturate at 16'hFFFF.
- When undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- LDR word, addr=16'h3004, cache returns 16'hBEEF after 3 cycles -> dcache_read with address 16'h3004, be=2'b11; stall high through resp; rdata_out=16'hBEEF in DONE.
- LDB addr=16'h2001, rdata=16'h80_12 -> be=2'b10, rdata_out=16'hFF80. Then LDB addr=16'h2000 -> rdata_out=16'h0012.
- STB addr=16'h4003, wdata=16'h12A5 -> dcache_write, address 16'h4002, be=2'b10, dcache_wdata=16'hA5A5; rdata_out unchanged.
- LDI addr=16'h1000, pointer=16'h5000, data=16'h1234 -> first a read at 16'h1000, then a read at 16'h5000; rdata_out=16'h1234; stall spans both accesses.
- hold=1 for 4 cycles after completion -> state stays DONE, exactly one cache access issued; reset_n pulsed low mid-ACCESS -> all outputs 0 immediately, late resp ignored.
- With DCACHE_PERF_CNT_EN: one LDI with 1-cycle hits -> perf_accesses=2, perf_stall_cycles=3.
